// File: rtl/mem_block_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_block_arbiter
// Purpose  : Round-robin owner of the shared main-memory block port for the
//            I-cache (reads) and D-cache (reads and write-backs).
// Revision : 1.0 - initial release
// ============================================================================
module mem_block_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         i_read_req,
   input  logic [31:0]  i_address,
   output logic [255:0] i_block_data,
   output logic         i_accepted,
   input  logic         d_read_req,
   input  logic         d_write_req,
   input  logic [31:0]  d_address,
   input  logic [255:0] d_write_block,
   output logic [255:0] d_block_data,
   output logic         d_accepted,
   output logic         mem_read,
   output logic         mem_write,
   output logic [31:0]  mem_address,
   output logic [255:0] mem_write_block,
   input  logic [255:0] mem_read_block,
   input  logic         mem_read_valid,
   input  logic         mem_write_valid,
   output logic         busy,
   output logic         timeout_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GNT_I_RD = 2'd1,
      GNT_D_RD = 2'd2,
      GNT_D_WR = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] c_timeoutM1 = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic             r_lastD;
   logic [CNT_W-1:0] r_waitCnt;
   logic             r_timeoutErr;
   logic             w_dEligible;
   logic             w_complete;

   assign w_dEligible  = d_read_req | d_write_req;
   assign w_complete   = i_accepted | d_accepted;
   assign i_block_data = mem_read_block;
   assign d_block_data = mem_read_block;
   assign busy         = (r_state != IDLE);
   assign timeout_err  = r_timeoutErr;

   // Strobes and accepts are gated by the owning request so a withdrawn
   // request drops off the memory bus in the same cycle.
   always_comb begin
      w_nextState     = r_state;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = 32'd0;
      mem_write_block = 256'd0;
      i_accepted      = 1'b0;
      d_accepted      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_dEligible && (!i_read_req || !r_lastD)) begin
               w_nextState = d_write_req ? GNT_D_WR : GNT_D_RD;
            end else if (i_read_req) begin
               w_nextState = GNT_I_RD;
            end
         end
         GNT_I_RD: begin
            mem_read    = i_read_req;
            mem_address = i_address;
            i_accepted  = i_read_req & mem_read_valid;
            if (!i_read_req || mem_read_valid) begin
               w_nextState = IDLE;
            end
         end
         GNT_D_RD: begin
            mem_read    = d_read_req;
            mem_address = d_address;
            d_accepted  = d_read_req & mem_read_valid;
            if (!d_read_req || mem_read_valid) begin
               w_nextState = IDLE;
            end
         end
         GNT_D_WR: begin
            mem_write       = d_write_req;
            mem_address     = d_address;
            mem_write_block = d_write_block;
            d_accepted      = d_write_req & mem_write_valid;
            if (!d_write_req || mem_write_valid) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= IDLE;
         r_lastD <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (r_state == IDLE && w_nextState != IDLE) begin
            r_lastD <= (w_nextState != GNT_I_RD);
         end
      end
   end

   // Counter sits at zero while idle, so every grant starts counting from 0.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_waitCnt    <= '0;
         r_timeoutErr <= 1'b0;
      end else if (r_state == IDLE) begin
         r_waitCnt <= '0;
      end else if (!w_complete) begin
         if (r_waitCnt != c_timeout) begin
            r_waitCnt <= r_waitCnt + 1'b1;
         end
         if (r_waitCnt == c_timeoutM1) begin
            r_timeoutErr <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_block_arbiter.sv
`default_nettype none
// Self-checking bench for mem_block_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_block_arbiter;

   localparam int TO = 8;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         i_read_req;
   logic [31:0]  i_address;
   logic [255:0] i_block_data;
   logic         i_accepted;
   logic         d_read_req;
   logic         d_write_req;
   logic [31:0]  d_address;
   logic [255:0] d_write_block;
   logic [255:0] d_block_data;
   logic         d_accepted;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_write_block;
   logic [255:0] mem_read_block;
   logic         mem_read_valid;
   logic         mem_write_valid;
   logic         busy;
   logic         timeout_err;

   always #5 CLK = ~CLK;

   mem_block_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .i_read_req(i_read_req), .i_address(i_address),
      .i_block_data(i_block_data), .i_accepted(i_accepted),
      .d_read_req(d_read_req), .d_write_req(d_write_req),
      .d_address(d_address), .d_write_block(d_write_block),
      .d_block_data(d_block_data), .d_accepted(d_accepted),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_write_block(mem_write_block),
      .mem_read_block(mem_read_block), .mem_read_valid(mem_read_valid),
      .mem_write_valid(mem_write_valid), .busy(busy), .timeout_err(timeout_err)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the port (0 none, 1 I read, 2 D read, 3 D write)
   int mOwner;
   bit mLastD;
   int mWait;
   bit mErr;

   typedef struct {
      logic iReq, dRd, dWr, rdV, wrV;
      logic eRd, eWr, eIAcc, eDAcc, eBusy;
      logic [1:0] eSel;
   } vec_t;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clrIn();
      i_read_req = 0; d_read_req = 0; d_write_req = 0;
      mem_read_valid = 0; mem_write_valid = 0;
      i_address = 32'h0040_0020; d_address = 32'h1001_0040;
      d_write_block = {8{32'h1234_5678}};
      mem_read_block = {32{8'hA5}};
   endtask

   task automatic doReset();
      clrIn();
      RESET = 0;
      repeat (2) @(posedge CLK);
      #1 RESET = 1;
      mOwner = 0; mLastD = 0; mWait = 0; mErr = 0;
   endtask

   task automatic nextCycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic modelCheck();
      logic [31:0]  eAddr;
      logic [255:0] eWb;
      logic eRd, eWr, eIA, eDA;
      eRd = (mOwner == 1 && i_read_req) || (mOwner == 2 && d_read_req);
      eWr = (mOwner == 3 && d_write_req);
      eIA = (mOwner == 1 && i_read_req && mem_read_valid);
      eDA = (mOwner == 2 && d_read_req && mem_read_valid) ||
            (mOwner == 3 && d_write_req && mem_write_valid);
      eAddr = (mOwner == 1) ? i_address : (mOwner >= 2) ? d_address : 32'd0;
      eWb   = (mOwner == 3) ? d_write_block : 256'd0;
      chk("rnd_mem_read", mem_read, eRd);
      chk("rnd_mem_write", mem_write, eWr);
      chk("rnd_i_acc", i_accepted, eIA);
      chk("rnd_d_acc", d_accepted, eDA);
      chk("rnd_addr", mem_address, eAddr);
      chk("rnd_wblock", mem_write_block, eWb);
      chk("rnd_busy", busy, mOwner != 0);
      chk("rnd_timeout", timeout_err, mErr);
      chk("rnd_i_data", i_block_data, mem_read_block);
      chk("rnd_d_data", d_block_data, mem_read_block);
   endtask

   // Advance the model by one edge using the inputs presented this cycle.
   task automatic modelStep();
      bit held, done;
      if (mOwner == 0) begin
         if ((d_read_req || d_write_req) && (!i_read_req || !mLastD)) begin
            mOwner = d_write_req ? 3 : 2; mLastD = 1; mWait = 0;
         end else if (i_read_req) begin
            mOwner = 1; mLastD = 0; mWait = 0;
         end
      end else begin
         held = (mOwner == 1) ? i_read_req : (mOwner == 2) ? d_read_req : d_write_req;
         done = held && ((mOwner == 3) ? mem_write_valid : mem_read_valid);
         if (!done) begin
            mWait++;
            if (mWait >= TO) mErr = 1;
         end
         if (!held || done) mOwner = 0;
      end
   endtask

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0};
      tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1, 2'd1};
      tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b1, 2'd1};
      tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1, 2'd1};
      tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0};
      tbl[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1, 2'd2};
      tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b1, 2'd2};
      tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0};
      tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1, 2'd1};
      tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'd1};
      tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0};
      tbl[11] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1, 2'd2};
      tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0};

      // Reset state with every request and valid asserted
      clrIn();
      RESET = 0;
      i_read_req = 1; d_read_req = 1; d_write_req = 1;
      mem_read_valid = 1; mem_write_valid = 1;
      #13;
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_i_acc", i_accepted, 1'b0);
      chk("rst_d_acc", d_accepted, 1'b0);
      chk("rst_timeout", timeout_err, 1'b0);
      chk("rst_addr", mem_address, 32'd0);

      // Vector table
      doReset();
      for (int k = 0; k < 13; k++) begin
         logic [31:0] eAddr;
         i_read_req = tbl[k].iReq; d_read_req = tbl[k].dRd; d_write_req = tbl[k].dWr;
         mem_read_valid = tbl[k].rdV; mem_write_valid = tbl[k].wrV;
         #1;
         eAddr = (tbl[k].eSel == 2'd1) ? i_address : (tbl[k].eSel == 2'd2) ? d_address : 32'd0;
         chk($sformatf("tbl%0d_mem_read", k), mem_read, tbl[k].eRd);
         chk($sformatf("tbl%0d_mem_write", k), mem_write, tbl[k].eWr);
         chk($sformatf("tbl%0d_i_acc", k), i_accepted, tbl[k].eIAcc);
         chk($sformatf("tbl%0d_d_acc", k), d_accepted, tbl[k].eDAcc);
         chk($sformatf("tbl%0d_busy", k), busy, tbl[k].eBusy);
         chk($sformatf("tbl%0d_addr", k), mem_address, eAddr);
         chk($sformatf("tbl%0d_wblock", k), mem_write_block,
             tbl[k].eWr ? d_write_block : 256'd0);
         nextCycle();
      end

      // Single I read: valid at cycle 5
      doReset();
      i_read_req = 1;
      for (int c = 0; c <= 6; c++) begin
         mem_read_valid = (c == 5);
         #1;
         chk($sformatf("single_c%0d_mem_read", c), mem_read, (c >= 1 && c <= 5));
         chk($sformatf("single_c%0d_i_acc", c), i_accepted, (c == 5));
         chk($sformatf("single_c%0d_busy", c), busy, (c >= 1 && c <= 5));
         if (c >= 1 && c <= 5) chk($sformatf("single_c%0d_addr", c), mem_address, 32'h0040_0020);
         if (c == 5) chk("single_i_data", i_block_data, {32{8'hA5}});
         nextCycle();
         if (c == 5) i_read_req = 0;
      end

      // Simultaneous I and D reads after reset: D first, one bubble, then I
      doReset();
      i_read_req = 1; d_read_req = 1;
      for (int c = 0; c <= 5; c++) begin
         mem_read_valid = (c == 2 || c == 5);
         #1;
         chk($sformatf("sim_c%0d_mem_read", c), mem_read, (c == 1 || c == 2 || c == 4 || c == 5));
         chk($sformatf("sim_c%0d_d_acc", c), d_accepted, (c == 2));
         chk($sformatf("sim_c%0d_i_acc", c), i_accepted, (c == 5));
         if (c == 1) chk("sim_d_addr", mem_address, 32'h1001_0040);
         if (c == 4) chk("sim_i_addr", mem_address, 32'h0040_0020);
         nextCycle();
         if (c == 2) d_read_req = 0;
      end
      i_read_req = 0; mem_read_valid = 0;

      // Timeout: memory silent for a D read
      doReset();
      d_read_req = 1;
      for (int c = 0; c <= 11; c++) begin
         mem_read_valid = (c == 10);
         #1;
         chk($sformatf("to_c%0d_err", c), timeout_err, (c >= 9));
         if (c >= 1 && c <= 10) chk($sformatf("to_c%0d_mem_read", c), mem_read, 1'b1);
         if (c == 10) chk("to_d_acc", d_accepted, 1'b1);
         nextCycle();
         if (c == 10) d_read_req = 0;
      end
      RESET = 0;
      #1 chk("to_err_cleared", timeout_err, 1'b0);

      // Reset asserted mid GNT_D_RD, I request waiting
      doReset();
      d_read_req = 1;
      nextCycle();
      chk("rmid_mem_read_before", mem_read, 1'b1);
      mem_read_valid = 1; i_read_req = 1;
      #2 RESET = 0;
      #1;
      chk("rmid_mem_read_drop", mem_read, 1'b0);
      chk("rmid_d_acc", d_accepted, 1'b0);
      chk("rmid_busy", busy, 1'b0);
      d_read_req = 0; mem_read_valid = 0;
      @(posedge CLK);
      #1 RESET = 1;
      nextCycle();
      chk("rmid_i_grant", mem_read, 1'b1);
      chk("rmid_i_addr", mem_address, 32'h0040_0020);

      // Randomized run against the reference model
      for (int seg = 0; seg < 4; seg++) begin
         doReset();
         for (int c = 0; c < 300; c++) begin
            i_read_req      = ($urandom_range(0, 3) != 0);
            d_read_req      = ($urandom_range(0, 2) == 0);
            d_write_req     = ($urandom_range(0, 3) == 0);
            mem_read_valid  = ($urandom_range(0, 3 + seg * 2) == 0);
            mem_write_valid = ($urandom_range(0, 3 + seg * 2) == 0);
            i_address       = $urandom;
            d_address       = $urandom;
            d_write_block   = {8{$urandom}};
            mem_read_block  = {8{$urandom}};
            #1;
            modelCheck();
            @(posedge CLK);
            modelStep();
            #1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_block_arbiter.md
# mem_block_arbiter

Shares the single main-memory block port between the instruction cache (block reads only) and the data cache (block reads and write-backs). It sits between both cache miss interfaces and the memory-side `iBlkRead`/`dBlkRead`/`dBlkWrite` signalling:
- registers one grant at a time;
- holds it until memory accepts;
- alternates between the caches under contention;
- flags a memory transaction that never completes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: cycles a granted transaction may wait for memory acceptance before `timeout_err` sets.
- CNT_W, 11: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- i_read_req  in  1  I-cache block-read request; level, held until `i_accepted`.
- i_address  in  32  I-cache block address.
- i_block_data  out  256  read block returned to I-cache.
- i_accepted  out  1  I-cache transaction completed this cycle.
- d_read_req  in  1  D-cache block-read request; level.
- d_write_req  in  1  D-cache write-back request; level.
- d_address  in  32  D-cache block address.
- d_write_block  in  256  write-back data.
- d_block_data  out  256  read block returned to D-cache.
- d_accepted  out  1  D-cache transaction completed this cycle.
- mem_read  out  1  block read to memory.
- mem_write  out  1  block write to memory.
- mem_address  out  32  memory block address.
- mem_write_block  out  256  memory write data.
- mem_read_block  in  256  memory read data.
- mem_read_valid  in  1  memory read accepted/complete this cycle.
- mem_write_valid  in  1  memory write accepted/complete this cycle.
- busy  out  1  a grant is held.
- timeout_err  out  1  sticky; a granted transaction exceeded TIMEOUT_CYCLES.

## Operation
State machine: IDLE, GNT_I_RD, GNT_D_RD, GNT_D_WR. Registered `last_d` bit records whether the most recent grant went to D.

IDLE arbitration (evaluated at the edge):
- D-cache eligible if `d_write_req | d_read_req`.
- I-cache eligible if `i_read_req`.
- Only one eligible: it is granted.
- Both eligible: grant D if `last_d==0`, otherwise grant I (round robin).
- D grant goes to GNT_D_WR if `d_write_req`, else GNT_D_RD. Write-back wins when both D requests are high.
- `last_d` updates on every grant.

Outputs by state (all combinational from state and inputs):
- GNT_I_RD: `mem_read=1`, `mem_address=i_address`.
- GNT_D_RD: `mem_read=1`, `mem_address=d_address`.
- GNT_D_WR: `mem_write=1`, `mem_address=d_address`, `mem_write_block=d_write_block`.
- IDLE: `mem_read=mem_write=0`; `mem_address` and `mem_write_block` are 0.

Completion:
- In GNT_I_RD: `i_accepted = mem_read_valid`.
- In GNT_D_RD: `d_accepted = mem_read_valid`.
- In GNT_D_WR: `d_accepted = mem_write_valid`.
- The accepted signal is 0 in every other state.
- The state returns to IDLE on the edge ending the completion cycle.
- `i_block_data` and `d_block_data` both equal `mem_read_block` at all times; a requester samples it only with its accepted signal.

Request withdrawal:
- If the granted request drops before completion (`i_read_req` low in GNT_I_RD, the relevant D request low in a D state), the arbiter returns to IDLE next edge with no accepted pulse.
- The memory request is deasserted in that same cycle, because it is gated by the request.

Wait counter:
- Clears on entry to any grant state.
- Increments each cycle in a grant state without completion, and saturates.
- Reaching TIMEOUT_CYCLES sets `timeout_err`. It clears only on reset; the grant is kept.

`busy = (state != IDLE)`.

## Timing
Reset values (asynchronous, while RESET=0):
- state=IDLE, `last_d=0`, counter=0, `timeout_err=0`.
- Therefore all strobes are 0 and `busy=0`.

Latency:
- Request first high in cycle n → memory strobe in cycle n+1.
- Completion in cycle m (≥ n+1) → accepted pulse in cycle m (zero added latency) → IDLE in m+1.
- A pending request is regranted at the m+1 edge; its strobe appears in m+2. This is one bubble cycle per transaction.

Boundary and ordering rules:
- A valid input arriving in a non-matching state (e.g., `mem_write_valid` in GNT_I_RD) is ignored.
- A new request arriving while granted waits; it is never preempted.
- Reset asserted mid-grant: strobes drop immediately and no accepted pulse is generated.

## Test plan
- Single I read: `i_read_req=1` with `i_address=0x00400020` at cycle 0; memory asserts valid at cycle 5 with block 0xA5…A5 → `mem_read=1`, address 0x00400020 in cycles 1–5; `i_accepted=1` only in cycle 5; IDLE at 6.
- Simultaneous I and D reads after reset → D granted first (cycle 1). After D completes, I is granted two cycles later (one bubble); `d_accepted` and `i_accepted` pulse once each.
- Sustained D requests plus sustained I request, memory valid one cycle after each grant → grants alternate D, I, D, I.
- `d_write_req` and `d_read_req` both high, `d_address=0x10010040`, write data 0x1234… → `mem_write=1` (not `mem_read`), data matches; completes on `mem_write_valid` only; `mem_read_valid` pulses in that state are ignored.
- TIMEOUT_CYCLES=8, memory never responds → `timeout_err` rises 8 cycles after the grant; strobe stays high; `timeout_err` persists after later completion until RESET.
- RESET pulled low during GNT_D_RD → `mem_read` falls asynchronously, no `d_accepted`; after release with `i_read_req` held, I is granted in the next cycle.
